elevator_request_manager: RTL and testbench

ELEVATOR_REQUEST_MANAGER -- requirements
Module: elevator_request_manager

---
 rtl/elevator_request_manager.sv | 134 +++++++++++++
 tb/tb_elevator_request_manager.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_request_manager.sv
// rtl/elevator_request_manager.sv - debounced button capture, pending lamps, service clear and retry pulses
// Bit order of internal 12-bit vectors: [3:0] car, [7:4] hall up, [11:8] hall down.
module elevator_request_manager #(
    parameter int DEBOUNCE     = 4,
    parameter int RETRY_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_car,
    input  logic [3:0] btn_up,
    input  logic [3:0] btn_down,
    input  logic [1:0] current_floor,
    input  logic       moving_up,
    input  logic       moving_down,
    input  logic       door_open,
    output logic [3:0] inside_request,
    output logic [3:0] call_up,
    output logic [3:0] call_down,
    output logic [3:0] car_lamp,
    output logic [3:0] up_lamp,
    output logic [3:0] down_lamp,
    output logic       pending_any
);

    localparam logic [3:0]  CNT_LAST    = 4'(DEBOUNCE - 1);
    localparam logic [7:0]  TMR_LAST    = 8'(RETRY_CYCLES - 1);
    // No up call from the top floor, no down call from the ground floor.
    localparam logic [11:0] ACCEPT_MASK = 12'b1110_0111_1111;

    typedef enum logic [1:0] {DIR_IDLE, DIR_UP, DIR_DOWN} dir_e;

    logic [1:0]  rst_sync_q;
    logic        rst_int_n;
    logic [11:0] raw;
    logic [11:0] sync0_q, sync1_q, db_q;
    logic [3:0]  cnt_q [12];
    logic [11:0] pend_q, pend_d;
    logic [11:0] pulse_q, pulse_d;
    logic [11:0] accept, clr;
    logic [3:0]  clr_car, clr_up, clr_dn;
    logic [7:0]  timer_q, timer_d;
    dir_e        dir_q, dir_d;
    logic        svc, retry_fire;

    // Assertion is immediate; release propagates through two flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];
    assign raw       = {btn_down, btn_up, btn_car};

    always_comb begin
        accept = '0;
        for (int i = 0; i < 12; i++) begin
            accept[i] = sync1_q[i] & ~db_q[i] & (cnt_q[i] == CNT_LAST);
        end
        accept = accept & ACCEPT_MASK;

        clr_car = '0;
        clr_up  = '0;
        clr_dn  = '0;
        if (door_open) begin
            clr_car[current_floor] = 1'b1;
            if (dir_q != DIR_DOWN || current_floor == 2'd0) clr_up[current_floor] = 1'b1;
            if (dir_q != DIR_UP || current_floor == 2'd3)   clr_dn[current_floor] = 1'b1;
        end
        clr = {clr_dn, clr_up, clr_car} & ACCEPT_MASK;

        svc        = |(pend_q & clr);
        retry_fire = (|pend_q) && (timer_q == TMR_LAST);
        pend_d     = (pend_q | accept) & ~clr;
        // A clear in the same cycle always wins over a new or retried pulse.
        pulse_d    = (accept & ~pend_q & ~clr) | (retry_fire ? (pend_q & ~clr) : 12'h000);

        if (!(|pend_q) || svc || retry_fire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 8'd1;
        end

        dir_d = dir_q;
        if (moving_up) begin
            dir_d = DIR_UP;
        end else if (moving_down) begin
            dir_d = DIR_DOWN;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync0_q <= '0;
            sync1_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 12; i++) cnt_q[i] <= '0;
            pend_q  <= '0;
            pulse_q <= '0;
            timer_q <= '0;
            dir_q   <= DIR_IDLE;
        end else begin
            sync0_q <= raw;
            sync1_q <= sync0_q;
            for (int i = 0; i < 12; i++) begin
                if (sync1_q[i] != db_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        db_q[i]  <= sync1_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
            pend_q  <= pend_d;
            pulse_q <= pulse_d;
            timer_q <= timer_d;
            dir_q   <= dir_d;
        end
    end

    assign inside_request = pulse_q[3:0];
    assign call_up        = pulse_q[7:4];
    assign call_down      = pulse_q[11:8];
    assign car_lamp       = pend_q[3:0];
    assign up_lamp        = pend_q[7:4];
    assign down_lamp      = pend_q[11:8];
    assign pending_any    = |pend_q;

endmodule

// File: tb/tb_elevator_request_manager.sv
// tb/tb_elevator_request_manager.sv - scoreboard bench for elevator_request_manager
module tb_elevator_request_manager;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_car = '0, btn_up = '0, btn_down = '0;
    logic [1:0] current_floor = '0;
    logic       moving_up = 1'b0, moving_down = 1'b0, door_open = 1'b0;
    logic [3:0] inside_request, call_up, call_down;
    logic [3:0] car_lamp, up_lamp, down_lamp;
    logic       pending_any;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int          cyc;
        logic [11:0] vec;
    } exp_t;
    exp_t sb[$];

    elevator_request_manager #(.DEBOUNCE(4), .RETRY_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .btn_car(btn_car), .btn_up(btn_up), .btn_down(btn_down),
        .current_floor(current_floor), .moving_up(moving_up),
        .moving_down(moving_down), .door_open(door_open),
        .inside_request(inside_request), .call_up(call_up), .call_down(call_down),
        .car_lamp(car_lamp), .up_lamp(up_lamp), .down_lamp(down_lamp),
        .pending_any(pending_any)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle the pulse outputs must match the scoreboard head or be zero.
    always @(negedge clk) begin
        logic [11:0] pulses;
        pulses = {call_down, call_up, inside_request};
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse cyc=%0d expected=%h never seen", sb[0].cyc, sb[0].vec);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                checks++;
                if (pulses !== sb[0].vec) begin
                    errors++;
                    $display("FAIL pulse cyc=%0d got=%h expected=%h", cyc, pulses, sb[0].vec);
                end
                void'(sb.pop_front());
            end else begin
                checks++;
                if (pulses !== 12'h000) begin
                    errors++;
                    $display("FAIL unexpected_pulse cyc=%0d got=%h expected=000", cyc, pulses);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL leftover_expectations got=%0d expected=0", sb.size());
        end
        sb.delete();
        btn_car = '0; btn_up = '0; btn_down = '0;
        door_open = 1'b0; moving_up = 1'b0; moving_down = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic push_exp(input int c, input logic [11:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({inside_request, call_up, call_down} !== 12'h000) begin
            errors++;
            $display("FAIL reset_pulses got=%h expected=000", {inside_request, call_up, call_down});
        end
        checks++;
        if ({car_lamp, up_lamp, down_lamp, pending_any} !== 13'h0) begin
            errors++;
            $display("FAIL reset_lamps got=%h expected=0", {car_lamp, up_lamp, down_lamp, pending_any});
        end
    endtask

    task automatic test_car_press();
        apply_reset();
        @(negedge clk);
        btn_car = 4'b0100;
        push_exp(cyc + 6, 12'h004);
        repeat (20) @(negedge clk);
        btn_car = 4'b0000;
        repeat (12) @(negedge clk);
        checks++;
        if (car_lamp !== 4'b0100) begin
            errors++;
            $display("FAIL car_lamp_held got=%b expected=0100", car_lamp);
        end
        checks++;
        if (pending_any !== 1'b1) begin
            errors++;
            $display("FAIL pending_any_car got=%b expected=1", pending_any);
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        @(negedge clk);
        btn_up = 4'b0010;
        repeat (3) @(negedge clk);
        btn_up = 4'b0000;
        repeat (10) @(negedge clk);
        checks++;
        if (up_lamp !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_lamp got=%b expected=0000", up_lamp);
        end
        btn_up = 4'b0010;
        push_exp(cyc + 6, 12'h020);
        repeat (4) @(negedge clk);
        btn_up = 4'b0000;
        repeat (10) @(negedge clk);
        checks++;
        if (up_lamp !== 4'b0010) begin
            errors++;
            $display("FAIL four_cycle_lamp got=%b expected=0010", up_lamp);
        end
    endtask

    task automatic test_service();
        apply_reset();
        @(negedge clk);
        btn_up = 4'b0010;
        push_exp(cyc + 6, 12'h020);
        repeat (8) @(negedge clk);
        btn_up = 4'b0000;
        moving_up = 1'b1;
        @(negedge clk);
        moving_up = 1'b0;
        current_floor = 2'd1;
        door_open = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (up_lamp !== 4'b0000 || pending_any !== 1'b0) begin
            errors++;
            $display("FAIL service_up_dir_up got=%b/%b expected=0000/0", up_lamp, pending_any);
        end

        apply_reset();
        @(negedge clk);
        btn_up = 4'b0010;
        push_exp(cyc + 6, 12'h020);
        repeat (8) @(negedge clk);
        btn_up = 4'b0000;
        moving_down = 1'b1;
        @(negedge clk);
        moving_down = 1'b0;
        current_floor = 2'd1;
        door_open = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (up_lamp !== 4'b0010 || pending_any !== 1'b1) begin
            errors++;
            $display("FAIL service_up_dir_down got=%b/%b expected=0010/1", up_lamp, pending_any);
        end
    endtask

    task automatic test_clear_wins();
        apply_reset();
        @(negedge clk);
        btn_car = 4'b0010;
        repeat (5) @(negedge clk);
        current_floor = 2'd1;
        door_open = 1'b1;
        @(negedge clk);
        door_open = 1'b0;
        checks++;
        if (car_lamp !== 4'b0000) begin
            errors++;
            $display("FAIL accept_vs_clear got=%b expected=0000", car_lamp);
        end
        repeat (10) @(negedge clk);
        btn_car = 4'b0000;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        btn_car = 4'b0010;
        btn_up = 4'b0100;
        btn_down = 4'b0010;
        push_exp(cyc + 6, 12'h242);
        repeat (10) @(negedge clk);
        btn_car = '0; btn_up = '0; btn_down = '0;
        repeat (4) @(negedge clk);
        checks++;
        if ({down_lamp, up_lamp, car_lamp} !== 12'h242) begin
            errors++;
            $display("FAIL multi_lamps got=%h expected=242", {down_lamp, up_lamp, car_lamp});
        end

        apply_reset();
        @(negedge clk);
        btn_car = 4'b1000;
        push_exp(cyc + 6, 12'h008);
        repeat (10) @(negedge clk);
        btn_car = 4'b0000;
        repeat (12) @(negedge clk);
        btn_car = 4'b1000;
        repeat (12) @(negedge clk);
        btn_car = 4'b0000;
        repeat (4) @(negedge clk);
        checks++;
        if (car_lamp !== 4'b1000) begin
            errors++;
            $display("FAIL repress_lamp got=%b expected=1000", car_lamp);
        end
    endtask

    task automatic test_retry();
        int a;
        apply_reset();
        @(negedge clk);
        btn_down = 4'b1000;
        a = cyc + 6;
        push_exp(a, 12'h800);
        push_exp(a + 64, 12'h800);
        push_exp(a + 128, 12'h800);
        repeat (10) @(negedge clk);
        btn_down = 4'b0000;
        for (int k = 0; k < 200 && cyc < a + 135; k++) @(negedge clk);
        checks++;
        if (cyc < a + 135) begin
            errors++;
            $display("FAIL retry_timeout got=%0d expected>=%0d", cyc, a + 135);
        end
        checks++;
        if (down_lamp !== 4'b1000) begin
            errors++;
            $display("FAIL retry_lamp got=%b expected=1000", down_lamp);
        end
    endtask

    task automatic test_ignored();
        apply_reset();
        @(negedge clk);
        btn_up = 4'b1000;
        btn_down = 4'b0001;
        repeat (15) @(negedge clk);
        checks++;
        if (up_lamp !== 4'b0000 || down_lamp !== 4'b0000 || pending_any !== 1'b0) begin
            errors++;
            $display("FAIL ignored_lamps got=%b/%b/%b expected=0000/0000/0", up_lamp, down_lamp, pending_any);
        end
        btn_up = '0;
        btn_down = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        btn_car = 4'b0001;
        push_exp(cyc + 6, 12'h001);
        repeat (8) @(negedge clk);
        btn_car = 4'b0000;
        repeat (10) @(negedge clk);
        checks++;
        if (car_lamp !== 4'b0001) begin
            errors++;
            $display("FAIL pre_reset_lamp got=%b expected=0001", car_lamp);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({car_lamp, up_lamp, down_lamp, inside_request, call_up, call_down, pending_any} !== 25'h0) begin
            errors++;
            $display("FAIL async_reset got=%h expected=0",
                     {car_lamp, up_lamp, down_lamp, inside_request, call_up, call_down, pending_any});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (car_lamp !== 4'b0000) begin
            errors++;
            $display("FAIL post_reset_lamp got=%b expected=0000", car_lamp);
        end

        btn_car = 4'b0010;
        push_exp(cyc + 6, 12'h002);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        push_exp(cyc + 8, 12'h002);
        repeat (12) @(negedge clk);
        btn_car = 4'b0000;
        repeat (10) @(negedge clk);
        checks++;
        if (car_lamp !== 4'b0010) begin
            errors++;
            $display("FAIL held_through_reset got=%b expected=0010", car_lamp);
        end
    endtask

    initial begin
        mon_en = 1'b1;
        test_reset();
        test_car_press();
        test_glitch();
        test_service();
        test_clear_wins();
        test_back_to_back();
        test_retry();
        test_ignored();
        test_reset_mid();
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL final_scoreboard got=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
